// File: rtl/sipo_pkg.sv
// Shared constants and types for the serial-in, parallel-out word collector.
package sipo_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  // Bit-counter width able to hold 0..width.
  function automatic int unsigned count_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_hold_buf.sv
// One-entry valid/ready holding register; flags overrun when a word arrives while full and not popped.
module sipo_hold_buf
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             overrun
);

  logic pop_c;

  always_comb begin
    pop_c = valid && ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (load && (!valid || pop_c)) begin
        data  <= load_data;
        valid <= 1'b1;
      end else if (pop_c) begin
        valid <= 1'b0;
      end

      // A word completing against a stalled full buffer is dropped.
      if (clr_ovr) begin
        overrun <= 1'b0;
      end else if (load && valid && !pop_c) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sipo_word_collector.sv
// Serial-to-parallel word collector: assembles WIDTH-bit words MSB- or LSB-first into a valid/ready buffer.
module sipo_word_collector
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_in,
  input  logic             s_valid,
  input  logic             msb_first,
  input  logic             clear,
  output logic [WIDTH-1:0] p_data,
  output logic             p_valid,
  input  logic             p_ready,
  output logic             overrun,
  output logic             busy
);

  localparam int unsigned CW = count_width(WIDTH);

  state_e           state;
  logic [CW-1:0]    count;
  logic             dir;
  logic [WIDTH-1:0] shreg;

  logic             dir_c;
  logic [WIDTH-1:0] shifted_c;
  logic             complete_c;

  // Direction comes live from msb_first on the first bit, then from the latch.
  always_comb begin
    dir_c      = (state == IDLE) ? msb_first : dir;
    shifted_c  = dir_c ? {shreg[WIDTH-2:0], s_in} : {s_in, shreg[WIDTH-1:1]};
    complete_c = s_valid && !clear && (state == COLLECT) && (count == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      dir   <= 1'b1;
      shreg <= '0;
      busy  <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      count <= '0;
      shreg <= '0;
      busy  <= 1'b0;
    end else if (s_valid) begin
      shreg <= shifted_c;
      case (state)
        IDLE: begin
          dir   <= msb_first;
          count <= CW'(1);
          state <= COLLECT;
          busy  <= 1'b1;
        end
        COLLECT: begin
          if (count == CW'(WIDTH - 1)) begin
            count <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            count <= count + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  sipo_hold_buf #(
    .WIDTH(WIDTH)
  ) u_hold_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (complete_c),
    .load_data(shifted_c),
    .ready    (p_ready),
    .clr_ovr  (clear),
    .data     (p_data),
    .valid    (p_valid),
    .overrun  (overrun)
  );

endmodule
